// File: rtl/mux_arb_4.sv
// mux_arb_4: round-robin arbiter and sequencer for a shared 4:1 single-bit mux.
// One requester owns the mux at a time. A one-cycle RELEASE bubble separates owners.
// An optional HOLD_MAX limit forces a release after that many grant cycles.
// Optional feature macro: MUX_ARB_LOCK_EN adds a `lock` input. While lock is high
// during GRANT, the HOLD_MAX forced release is suppressed.
module mux_arb_4 #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    input  logic [3:0] d,
`ifdef MUX_ARB_LOCK_EN
    input  logic       lock,
`endif
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       y,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // A zero HOLD_MAX disables the limit. The threshold is the counter value
    // seen on the last allowed grant cycle.
    localparam logic       HOLD_EN = (HOLD_MAX != 0);
    localparam logic [7:0] HOLD_M1 = 8'(HOLD_MAX - 1);

    state_t     state_r, state_s;
    logic [3:0] gnt_r,   gnt_s;
    logic [1:0] sel_r,   sel_s;
    logic       y_r,     y_s;
    logic       busy_r,  busy_s;
    logic [1:0] last_r,  last_s;
    logic [7:0] hold_r,  hold_s;

    logic [2:0] pick_s;
    logic       any_s;
    logic [1:0] win_s;
    logic       force_rel_s;

    // Round-robin search starting just above the last owner.
    // Returns {found, index}.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] idx;
        logic       found;
        logic [1:0] win;
        found = 1'b0;
        win   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = last + 2'd1 + 2'(i);
            if (!found && r[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return {found, win};
    endfunction

    // Arbitration winner and forced-release decision for the current cycle.
    always_comb begin
        pick_s = rr_pick(req, last_r);
        any_s  = pick_s[2];
        win_s  = pick_s[1:0];
`ifdef MUX_ARB_LOCK_EN
        force_rel_s = HOLD_EN && !lock && (hold_r >= HOLD_M1);
`else
        force_rel_s = HOLD_EN && (hold_r >= HOLD_M1);
`endif
    end

    // Next-state and next-output logic. Every register holds by default.
    always_comb begin
        state_s = state_r;
        gnt_s   = gnt_r;
        sel_s   = sel_r;
        y_s     = y_r;
        last_s  = last_r;
        hold_s  = hold_r;
        case (state_r)
            ST_IDLE, ST_RELEASE: begin
                if (any_s) begin
                    state_s = ST_GRANT;
                    sel_s   = win_s;
                    last_s  = win_s;
                    gnt_s   = 4'b0001 << win_s;
                    hold_s  = 8'd0;
                end else begin
                    state_s = ST_IDLE;
                    gnt_s   = 4'b0000;
                end
            end
            ST_GRANT: begin
                y_s    = d[sel_r];
                hold_s = (hold_r == 8'hFF) ? hold_r : (hold_r + 8'd1);
                if (!req[sel_r] || force_rel_s) begin
                    state_s = ST_RELEASE;
                    gnt_s   = 4'b0000;
                end else begin
                    state_s = ST_GRANT;
                end
            end
            default: begin
                state_s = ST_IDLE;
                gnt_s   = 4'b0000;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers. Reset sets the owner pointer to 3,
    // so requester 0 has top priority afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            gnt_r   <= 4'b0000;
            sel_r   <= 2'd0;
            y_r     <= 1'b0;
            busy_r  <= 1'b0;
            last_r  <= 2'd3;
            hold_r  <= 8'd0;
        end else begin
            state_r <= state_s;
            gnt_r   <= gnt_s;
            sel_r   <= sel_s;
            y_r     <= y_s;
            busy_r  <= busy_s;
            last_r  <= last_s;
            hold_r  <= hold_s;
        end
    end

    assign gnt  = gnt_r;
    assign sel  = sel_r;
    assign y    = y_r;
    assign busy = busy_r;

endmodule

// File: tb/tb_mux_arb_4.sv
// Directed testbench for mux_arb_4. Two instances share the stimulus:
// u_dut8 uses the default HOLD_MAX=8 and u_dut2 uses HOLD_MAX=2.
// Each test checks only the instance it targets.
module tb_mux_arb_4;

    logic       clk;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] d;
    logic       lock;
    logic [3:0] gnt8, gnt2;
    logic [1:0] sel8, sel2;
    logic       y8, y2;
    logic       busy8, busy2;

    int n_cmp;
    int n_err;

    mux_arb_4 u_dut8 (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .d       (d),
`ifdef MUX_ARB_LOCK_EN
        .lock    (lock),
`endif
        .gnt     (gnt8),
        .sel     (sel8),
        .y       (y8),
        .busy    (busy8)
    );

    mux_arb_4 #(.HOLD_MAX(2)) u_dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .d       (d),
`ifdef MUX_ARB_LOCK_EN
        .lock    (lock),
`endif
        .gnt     (gnt2),
        .sel     (sel2),
        .y       (y2),
        .busy    (busy2)
    );

    // Free-running clock with a 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Advance one rising edge, then settle 1 ns so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse the asynchronous reset between clock edges.
    task automatic do_reset();
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
    endtask

    logic [3:0] exp_rr [13];
    logic [3:0] d_pat  [6];

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        req     = 4'b0000;
        d       = 4'b0000;
        lock    = 1'b0;
        tick();

        // Check the reset state.
        check_val("rst_gnt",  8'(gnt8),  8'h00);
        check_val("rst_sel",  8'(sel8),  8'h00);
        check_val("rst_y",    8'(y8),    8'h00);
        check_val("rst_busy", 8'(busy8), 8'h00);
        reset_n = 1'b1;

        // Single requester 0, held for 3 edges (HOLD_MAX=8 instance).
        req = 4'b0001;
        d   = 4'b0001;
        tick();
        check_val("t1_gnt",  8'(gnt8),  8'h01);
        check_val("t1_sel",  8'(sel8),  8'h00);
        check_val("t1_busy", 8'(busy8), 8'h01);
        check_val("t1_y0",   8'(y8),    8'h00);
        tick();
        check_val("t1_y1",   8'(y8),    8'h01);
        check_val("t1_gnt2", 8'(gnt8),  8'h01);
        tick();
        check_val("t1_gnt3", 8'(gnt8),  8'h01);
        req = 4'b0000;
        tick();
        check_val("t1_rel_gnt",  8'(gnt8),  8'h00);
        check_val("t1_rel_busy", 8'(busy8), 8'h01);
        check_val("t1_rel_y",    8'(y8),    8'h01);
        tick();
        check_val("t1_idle_busy", 8'(busy8), 8'h00);
        check_val("t1_idle_gnt",  8'(gnt8),  8'h00);
        check_val("t1_idle_y",    8'(y8),    8'h01);

        // All four requesting, HOLD_MAX=2: order 0,1,2,3,0 with one-cycle bubbles.
        do_reset();
        exp_rr = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                   4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
        req = 4'b1111;
        for (int i = 0; i < 13; i++) begin
            tick();
            check_val($sformatf("rr_gnt%0d", i), 8'(gnt2), 8'(exp_rr[i]));
        end

        // Lone requester 2, HOLD_MAX=2: forced release and re-grant after the bubble.
        do_reset();
        req = 4'b0100;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_val($sformatf("solo_gnt%0d", i), 8'(gnt2), ((i % 3) == 2) ? 8'h00 : 8'h04);
            check_val($sformatf("solo_sel%0d", i), 8'(sel2), 8'h02);
        end

        // Asynchronous reset in the middle of owner 1's grant.
        do_reset();
        req = 4'b0010;
        d   = 4'b0010;
        tick();
        check_val("ar_gnt1", 8'(gnt2), 8'h02);
        check_val("ar_sel1", 8'(sel2), 8'h01);
        tick();
        check_val("ar_y1",   8'(y2),   8'h01);
        req     = 4'b0011;
        reset_n = 1'b0;
        #1;
        check_val("ar_gnt0",  8'(gnt2),  8'h00);
        check_val("ar_sel0",  8'(sel2),  8'h00);
        check_val("ar_y0",    8'(y2),    8'h00);
        check_val("ar_busy0", 8'(busy2), 8'h00);
        reset_n = 1'b1;
        tick();
        check_val("ar_regnt", 8'(gnt2), 8'h01);

        // Owner 2 with d toggling (HOLD_MAX=8 instance): y follows d[2] one edge later.
        do_reset();
        req   = 4'b0100;
        d     = 4'b0000;
        d_pat = '{4'b0100, 4'b1011, 4'b0100, 4'b1111, 4'b0000, 4'b1011};
        tick();
        check_val("dt_gnt", 8'(gnt8), 8'h04);
        for (int i = 0; i < 6; i++) begin
            d = d_pat[i];
            #2;
            check_val($sformatf("dt_hold%0d", i), 8'(y8), (i == 0) ? 8'h00 : 8'(d_pat[i-1][2]));
            tick();
            check_val($sformatf("dt_y%0d", i), 8'(y8), 8'(d_pat[i][2]));
        end

`ifdef MUX_ARB_LOCK_EN
        // With lock held, the HOLD_MAX=2 limit is suppressed until lock falls.
        do_reset();
        req  = 4'b0011;
        lock = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val($sformatf("lk_gnt%0d", i), 8'(gnt2), 8'h01);
        end
        lock = 1'b0;
        tick();
        check_val("lk_rel",  8'(gnt2), 8'h00);
        tick();
        check_val("lk_next", 8'(gnt2), 8'h02);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mux_arb_4.md
# mux_arb_4

Round-robin arbiter and sequencer for the shared 4:1 single-bit mux datapath. Four requesters compete for the mux. The block grants one requester at a time, drives the mux select from the grant, and registers the selected data bit. It enforces a one-cycle bubble between owners and an optional hold limit, so select changes never occur while an output is being consumed.

## Interface
- `HOLD_MAX`, default 8: maximum consecutive GRANT cycles per ownership. 0 means unlimited. Legal range is 0..255.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `req` input 4: per-requester request, level-sensitive, held while the requester wants the mux.
- `d` input 4: mux data inputs; `d[i]` belongs to requester i.
- `gnt` output 4: one-hot grant, registered. All zero outside GRANT.
- `sel` output 2: mux select, registered; the index of the current or most recent owner.
- `y` output 1: registered selected data bit.
- `busy` output 1: high in GRANT and RELEASE.
- `lock` input 1: present only with `MUX_ARB_LOCK_EN` (see Configuration).

## Operation
- States: IDLE, GRANT, RELEASE. Reset state is IDLE.
- Reset values: `gnt`=0000, `sel`=00, `y`=0, `busy`=0. Internal `last`=3 and `hold_cnt`=0.
- Arbitration is combinational on `req`:
  - Search starts at index (`last`+1) mod 4 and wraps upward.
  - The first index with `req` high wins.
  - After reset, requester 0 has top priority.
- IDLE:
  - If any `req` is high, go to GRANT.
  - Load the winner into `sel` and `last`, set `gnt` to the winner's one-hot, clear `hold_cnt`.
  - Otherwise stay in IDLE.
- GRANT:
  - Each cycle: `y` <= `d[sel]` and `hold_cnt` increments (saturating at 255).
  - Go to RELEASE if `req[sel]` is low.
  - Also go to RELEASE if `HOLD_MAX`≠0 and `hold_cnt`==`HOLD_MAX`-1 (forced release).
  - Otherwise stay in GRANT.
- RELEASE:
  - `gnt`=0000. `sel` and `y` hold their values.
  - Arbitrate with the updated `last`. If any `req` is high, go to GRANT with the winner. Otherwise go to IDLE.
- After a forced release, the previous owner has the lowest priority. If it is the only requester, it is re-granted after the bubble.
- `sel` changes only on an IDLE→GRANT or RELEASE→GRANT edge, never mid-grant.
- `y` holds its value outside GRANT.
- Requests that appear or drop for non-owners during GRANT have no effect until the next arbitration.
- Asynchronous reset mid-grant immediately forces all outputs and state to their reset values. Arbitration resumes from requester 0.

## Timing
- `req` rising, sampled at edge N: `gnt` and `sel` valid after edge N (grant latency 1 cycle from IDLE).
- First `y` for the owner is valid after edge N+1. `y` then tracks `d[sel]` with one cycle of latency.
- Owner drops `req` before edge M: RELEASE after edge M. The next owner's `gnt` comes after edge M+1, so there is exactly one bubble cycle with `gnt`=0.
- Maximum `gnt` high time is `HOLD_MAX` cycles (when `HOLD_MAX`≠0 and no lock).
- Worst-case wait for a continuously requesting input is 3×(`HOLD_MAX`+1) cycles, with `HOLD_MAX`≠0.

## Configuration
- `MUX_ARB_LOCK_EN` defined:
  - Adds input `lock`.
  - While in GRANT with `lock`=1, the `HOLD_MAX` forced release is suppressed; only `req[sel]` low releases.
  - `hold_cnt` saturates and does not wrap.
  - A forced release happens on the first cycle with `lock`=0 and `hold_cnt`≥`HOLD_MAX`-1.
- Not defined: the `lock` port is absent and the `HOLD_MAX` limit always applies.

## Test plan
- Reset, then `req`=0001 with `d`=0001, held 3 cycles:
  - `gnt`=0001 after the first edge and `sel`=00.
  - `y`=1 from the next edge.
  - After `req` drops: one RELEASE cycle, then IDLE with `busy`=0.
- `req`=1111 held, `HOLD_MAX`=2:
  - Grant order is 0,1,2,3,0.
  - Each grant lasts 2 cycles, separated by exactly one `gnt`=0000 cycle.
- `req`=0100 only, `HOLD_MAX`=2: the pattern is `gnt`=0100 for 2 cycles, 0000 for 1 cycle, repeating. `sel` stays 10.
- Owner 1 granted, `reset_n` pulsed low mid-GRANT: outputs go to 0 immediately without waiting for a clock edge. With `req`=0011, the next grant goes to requester 0.
- `MUX_ARB_LOCK_EN`, `HOLD_MAX`=2, `req`=0011, `lock`=1 for 5 cycles then 0:
  - `gnt`=0001 persists for 5 cycles.
  - After `lock` falls: forced release on the next edge, then `gnt`=0010.
- `d` toggling during GRANT of owner 2: `y` follows `d[2]` with one cycle of delay. Changes on `d[0]`, `d[1]` and `d[3]` have no effect.
